// File: rtl/euclid_pkg.sv
// Shared constants for the RS(15,11) key-equation stage: iteration count,
// control-word layout and sequencer state encodings.
package euclid_pkg;

    localparam int unsigned T        = 2;
    localparam int unsigned NUM_ITER = 2 * T;
    localparam int unsigned CTRL_W   = 5;
    localparam int unsigned ST_W     = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [ST_W-1:0] ST_CHECK = 3'd2;
    localparam logic [ST_W-1:0] ST_CALC  = 3'd3;
    localparam logic [ST_W-1:0] ST_SHIFT = 3'd4;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd5;

    localparam int unsigned CTRL_LOAD  = 0;
    localparam int unsigned CTRL_CHECK = 1;
    localparam int unsigned CTRL_CALC  = 2;
    localparam int unsigned CTRL_SHIFT = 3;
    localparam int unsigned CTRL_DONE  = 4;

    // One-hot control word driven while in a given state; unencoded states are idle.
    function automatic logic [CTRL_W-1:0] state_ctrl(input logic [ST_W-1:0] st);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (st)
            ST_LOAD:  c[CTRL_LOAD]  = 1'b1;
            ST_CHECK: c[CTRL_CHECK] = 1'b1;
            ST_CALC:  c[CTRL_CALC]  = 1'b1;
            ST_SHIFT: c[CTRL_SHIFT] = 1'b1;
            ST_DONE:  c[CTRL_DONE]  = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/euclid_controller.sv
// Free-running sequencer for the Euclidean key-equation datapath: LOAD, 2T rounds of
// CHECK/CALC/SHIFT, then DONE, repeating back-to-back.
module euclid_controller #(
    parameter int unsigned T = euclid_pkg::T
) (
    input  logic                        CLK,
    input  logic                        RESET,
    output logic [euclid_pkg::CTRL_W-1:0] CONTROL
);
    import euclid_pkg::*;

    localparam int unsigned ITERS  = 2 * T;
    localparam int unsigned ITER_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERS - 1);

    // Power-up values match reset so the block is defined without a reset pulse.
    logic [ST_W-1:0]   state_q   = ST_IDLE;
    logic [ST_W-1:0]   state_d;
    logic [ITER_W-1:0] iter_q    = '0;
    logic [ITER_W-1:0] iter_d;
    logic [CTRL_W-1:0] control_q = '0;

    // Next-state and iteration-counter logic.
    always_comb begin
        state_d = ST_IDLE;
        iter_d  = iter_q;
        case (state_q)
            ST_IDLE:  state_d = ST_LOAD;
            ST_LOAD: begin
                iter_d  = '0;
                state_d = ST_CHECK;
            end
            ST_CHECK: state_d = ST_CALC;
            ST_CALC:  state_d = ST_SHIFT;
            ST_SHIFT: begin
                // Hold the counter on the last round so it never wraps inside a frame.
                if (iter_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CHECK;
                    iter_d  = iter_q + ITER_W'(1);
                end
            end
            ST_DONE:  state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // CONTROL is registered from the next state so it tracks state_q with no input path.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            iter_q    <= '0;
            control_q <= '0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            control_q <= state_ctrl(state_d);
        end
    end

    assign CONTROL = control_q;

endmodule

// File: tb/tb_euclid_controller.sv
// Self-checking bench for euclid_controller: directed per-edge vector table plus
// multi-frame, reset-corner and T=3 sequences.
module tb_euclid_controller;
    import euclid_pkg::*;

    typedef struct {
        logic       rst;
        logic [4:0] exp;
    } vec_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       rst3 = 1'b0;
    logic [4:0] ctrl;
    logic [4:0] ctrl3;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    euclid_controller #(.T(2)) u_dut (
        .CLK    (clk),
        .RESET  (rst),
        .CONTROL(ctrl)
    );

    euclid_controller #(.T(3)) u_t3 (
        .CLK    (clk),
        .RESET  (rst3),
        .CONTROL(ctrl3)
    );

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    task automatic add(input logic r, input logic [4:0] e);
        vec_t v;
        v.rst = r;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic add_iters(input int n);
        for (int i = 0; i < n; i++) begin
            add(1'b0, 5'b00010);
            add(1'b0, 5'b00100);
            add(1'b0, 5'b01000);
        end
    endtask

    // Drive RESET just after an edge, then sample 1 time unit after the next edge.
    task automatic tick(input logic r);
        rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int last_load;
        int sh, ck, ca;
        int done_edge;
        int shifts3;
        bit  finished3;

        // Frame 1 from power-up, no reset ever applied.
        add(1'b0, 5'b00001);
        add_iters(4);
        add(1'b0, 5'b10000);
        // Frame 2 up to iteration-2 CALC, then reset held for three edges.
        add(1'b0, 5'b00001);
        add_iters(2);
        add(1'b0, 5'b00010);
        add(1'b0, 5'b00100);
        add(1'b1, 5'b00000);
        add(1'b1, 5'b00000);
        add(1'b1, 5'b00000);
        // Restart: full frame of four iterations, then reset on the DONE cycle.
        add(1'b0, 5'b00001);
        add_iters(4);
        add(1'b0, 5'b10000);
        add(1'b1, 5'b00000);
        add(1'b0, 5'b00001);
        add_iters(1);

        #1;
        check("powerup_idle", int'(ctrl), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].rst);
            checks++;
            if (ctrl !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec[%0d] rst=%0b: CONTROL got %b expected %b",
                         i, vecs[i].rst, ctrl, vecs[i].exp);
            end
        end

        // Continuous run: align on LOAD, then five full frames.
        n = 0;
        while (ctrl !== 5'b00001 && n < 20) begin
            tick(1'b0);
            n++;
        end
        check("sync_load", int'(ctrl), 1);
        last_load = 0;
        sh = 0; ck = 0; ca = 0;
        for (int c = 1; c <= 70; c++) begin
            tick(1'b0);
            check($sformatf("onehot_c%0d", c), $countones(ctrl), 1);
            if (ctrl[CTRL_CHECK]) ck++;
            if (ctrl[CTRL_CALC])  ca++;
            if (ctrl[CTRL_SHIFT]) sh++;
            if (ctrl[CTRL_DONE]) begin
                check($sformatf("frame_checks_c%0d", c), ck, 4);
                check($sformatf("frame_calcs_c%0d", c), ca, 4);
                check($sformatf("frame_shifts_c%0d", c), sh, 4);
                sh = 0; ck = 0; ca = 0;
            end
            if (ctrl[CTRL_LOAD]) begin
                check($sformatf("load_gap_c%0d", c), c - last_load, 14);
                last_load = c;
            end
        end
        check("last_load_edge", last_load, 70);

        // T=3 instance: reset once, then expect a 20-cycle frame with six iterations.
        rst3 = 1'b1;
        @(posedge clk);
        #1;
        check("t3_reset", int'(ctrl3), 0);
        rst3 = 1'b0;
        done_edge = 0;
        shifts3 = 0;
        finished3 = 1'b0;
        for (int k = 1; k <= 40 && !finished3; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("t3_first_load", int'(ctrl3), 1);
            if (done_edge == 0 && ctrl3[CTRL_SHIFT]) shifts3++;
            if (done_edge != 0) begin
                check("t3_load_after_done", int'(ctrl3), 1);
                finished3 = 1'b1;
            end else if (ctrl3[CTRL_DONE]) begin
                done_edge = k;
            end
        end
        check("t3_done_edge", done_edge, 20);
        check("t3_shifts", shifts3, 6);
        check("t3_finished", int'(finished3), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
